// File: rtl/bit_serial_alu_ctrl.sv
// -----------------------------------------------------------------------------
// bit_serial_alu_ctrl
//
// Bit-serial sequencer that performs WIDTH-bit ADD / SUB / AND / OR with a
// single 1-bit ALU slice. It processes one bit per clock, LSB first. Operands
// and the opcode are latched on a start handshake. The inter-bit carry is held
// in a register, and result bits shift into an accumulator from the MSB end.
// When the last bit is done, the result and flags are registered and a
// one-cycle done pulse is raised.
//
// Ports:
//   clk    : system clock, all state on rising edge
//   rst    : synchronous reset, active-high
//   start  : operation request, sampled only when not busy (IDLE or DONE)
//   op     : 00 ADD, 01 SUB (a-b), 10 AND, 11 OR; latched on accept
//   a, b   : WIDTH-bit operands; latched on accept
//   busy   : high while bits are being processed (RUN state)
//   done   : one-cycle pulse, result and flags valid
//   result : final result, held until the next completion
//   cout   : final carry for ADD/SUB (1 = no borrow on SUB), 0 for logic ops
//   zero   : result == 0
//   ovf    : signed overflow for ADD/SUB, 0 for logic ops
// -----------------------------------------------------------------------------
module bit_serial_alu_ctrl #(
  parameter int WIDTH = 8,
  parameter int CNT_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             cout,
  output logic             zero,
  output logic             ovf
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [1:0]       OP_ADD   = 2'b00;
  localparam logic [1:0]       OP_SUB   = 2'b01;
  localparam logic [1:0]       OP_AND   = 2'b10;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  state_t           state;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] acc;
  logic [1:0]       op_l;
  logic [CNT_W-1:0] cnt;
  logic             carry;

  // 1-bit ALU slice outputs
  logic             slice_r;
  logic             slice_cout;
  logic             b_eff;
  logic [WIDTH-1:0] acc_next;

  // ---------------------------------------------------------------------------
  // 1-bit ALU slice. SUB is a + ~b + 1: b is inverted here, and the +1 comes
  // from the carry register being preset to 1 on accept.
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every output gets a default first so that no path through the
    // case leaves it unassigned, which would infer a latch.
    slice_r    = 1'b0;
    slice_cout = 1'b0;
    b_eff      = b_sh[0] ^ (op_l == OP_SUB);
    case (op_l)
      OP_ADD, OP_SUB: begin
        slice_r    = a_sh[0] ^ b_eff ^ carry;
        slice_cout = (a_sh[0] & b_eff) | (carry & (a_sh[0] ^ b_eff));
      end
      OP_AND:  slice_r = a_sh[0] & b_sh[0];
      default: slice_r = a_sh[0] | b_sh[0];
    endcase
  end

  // The accumulator shifts right, so after WIDTH shifts bit 0 of the operands
  // has reached bit 0 of the accumulator.
  assign acc_next = {slice_r, acc[WIDTH-1:1]};

  // ---------------------------------------------------------------------------
  // Sequencer FSM with registered outputs
  // ---------------------------------------------------------------------------
  // NOTE: all state here uses non-blocking assignments. Every register then
  // sees the pre-edge values of the others, which the carry/shift chain needs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      a_sh   <= '0;
      b_sh   <= '0;
      acc    <= '0;
      op_l   <= OP_ADD;
      cnt    <= '0;
      carry  <= 1'b0;
      busy   <= 1'b0;
      done   <= 1'b0;
      result <= '0;
      cout   <= 1'b0;
      zero   <= 1'b0;
      ovf    <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE, DONE: begin
          if (start) begin
            a_sh  <= a;
            b_sh  <= b;
            op_l  <= op;
            cnt   <= '0;
            carry <= (op == OP_SUB);
            busy  <= 1'b1;
            state <= RUN;
          end else begin
            state <= IDLE;
          end
        end

        RUN: begin
          acc   <= acc_next;
          carry <= slice_cout;
          a_sh  <= {1'b0, a_sh[WIDTH-1:1]};
          b_sh  <= {1'b0, b_sh[WIDTH-1:1]};
          if (cnt == CNT_LAST) begin
            // MSB slice: carry still holds the carry into the MSB, and
            // slice_cout is the carry out of it.
            cnt    <= '0;
            busy   <= 1'b0;
            done   <= 1'b1;
            result <= acc_next;
            cout   <= slice_cout;
            zero   <= (acc_next == '0);
            ovf    <= ~op_l[1] & (carry ^ slice_cout);
            state  <= DONE;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule
